lsu_rmw: RTL and testbench

Load/store unit that sits between the RISC-V 64-bit datapath and the doubleword data memory (`dmem`). `dmem` only supports full 64-bit writes and combinational 64-bit reads. This block does three things: it performs byte, half, word and doubleword accesses; it sign- or zero-extends load data; and it turns sub-doubleword stores into a read-modify-write sequence. It flags misaligned or illegal accesses instead of touching memory.

---
 rtl/lsu_pkg.sv | 87 ++++++++
 rtl/lsu_lane_align.sv | 76 +++++++
 rtl/lsu_rmw.sv | 184 ++++++++++++++++++
 tb/tb_lsu_rmw.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
//
// Purpose:
//   Shared definitions for the doubleword load/store unit. These include the
//   RISC-V funct3 size/sign codes, the FSM state encoding, and helper
//   functions. The helpers turn an access size into a byte-lane mask and
//   classify a request as faulting.
//
// Contents:
//   F3_*          funct3 codes for byte/half/word/double, signed and unsigned
//   lsu_state_t   2-bit FSM state encoding (IDLE, ACCESS, WRITE, RESP)
//   size_mask     funct3[1:0] -> right-justified byte-enable mask
//   size_bytes    funct3[1:0] -> access width in bytes
//   access_fault  illegal-encoding or misalignment check for a request
// ---------------------------------------------------------------------------
package lsu_pkg;

  // Load encodings use all of funct3. Store encodings only use the low two
  // bits, and funct3[2] set is illegal for a store.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // The one funct3 value that is illegal for every load.
  localparam logic [2:0] F3_LOAD_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  // Byte-enable mask for an access of the given size, anchored at lane 0.
  // The caller shifts it up by the byte offset inside the doubleword.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    mask = 8'hFF;
    case (size)
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      2'b10:   mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    n = 4'd8;
    case (size)
      2'b00:   n = 4'd1;
      2'b01:   n = 4'd2;
      2'b10:   n = 4'd4;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  // A request faults when:
  //   - its encoding is illegal for its direction, or
  //   - its address is not a multiple of the access size.
  // Only the low three address bits matter, because no access is wider than
  // a doubleword.
  function automatic logic access_fault(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [2:0] offset);
    logic illegal;
    logic misaligned;
    illegal    = we ? funct3[2] : (funct3 == F3_LOAD_ILLEGAL);
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = offset[0];
      2'b10:   misaligned = |offset[1:0];
      2'b11:   misaligned = |offset;
      default: misaligned = 1'b0;
    endcase
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
//
// Purpose:
//   Purely combinational byte-lane steering for the load/store unit.
//   - Load path:  picks the lane at the byte offset from a 64-bit memory
//     doubleword (little-endian), then sign- or zero-extends it to 64 bits
//     according to funct3.
//   - Store path: merges the low bytes of the store data into a previously
//     read doubleword at the byte offset. This forms the write half of a
//     read-modify-write.
//
// Ports:
//   funct3     in   3  size/sign code of the access
//   offset     in   3  byte offset of the access inside the doubleword
//   rd         in  64  doubleword read from memory (or the merge buffer)
//   wdata      in  64  right-justified store data
//   load_data  out 64  extended load result
//   merged     out 64  rd with the addressed lanes replaced by wdata
// ---------------------------------------------------------------------------
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  offset,
  input  logic [63:0] rd,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  logic [5:0]  bit_offset;
  logic [63:0] rd_shifted;
  logic [63:0] wdata_shifted;
  logic [7:0]  byte_mask;

  assign bit_offset = {offset, 3'b000};

  // Bring the addressed lane down to bit 0, so extension only has to look
  // at a fixed bit position for each size.
  assign rd_shifted = rd >> bit_offset;

  // Extend the selected lane. A doubleword load needs no extension. The
  // illegal load encoding never reaches here, because the FSM faults it
  // first.
  always_comb begin
    load_data = rd_shifted;
    case (funct3)
      F3_B:    load_data = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
      F3_H:    load_data = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      F3_W:    load_data = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      F3_BU:   load_data = {56'd0, rd_shifted[7:0]};
      F3_HU:   load_data = {48'd0, rd_shifted[15:0]};
      F3_WU:   load_data = {32'd0, rd_shifted[31:0]};
      default: load_data = rd_shifted;
    endcase
  end

  // Store data moves up to the addressed lanes, and the size mask moves with
  // it. Aligned accesses never push mask bits past lane 7, so the 8-bit
  // truncation loses nothing.
  assign wdata_shifted = wdata << bit_offset;
  assign byte_mask     = size_mask(funct3[1:0]) << offset;

  // Replace enabled lanes with store data and keep every other lane from the
  // read doubleword.
  always_comb begin
    merged = rd;
    for (int i = 0; i < 8; i++) begin
      if (byte_mask[i]) begin
        merged[8*i +: 8] = wdata_shifted[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/lsu_rmw.sv
// ---------------------------------------------------------------------------
// lsu_rmw
//
// Purpose:
//   Load/store unit between a 64-bit datapath and a doubleword-only data
//   memory. The memory has a combinational read and a full-doubleword write.
//   - Loads of every width read the enclosing doubleword and extend the
//     addressed lane.
//   - Stores narrower than a doubleword become a read-modify-write: read,
//     merge, then write.
//   - Misaligned or illegally encoded requests complete with a fault and
//     never touch memory.
//
//   Flow: IDLE -> ACCESS -> (WRITE for stores) -> RESP -> IDLE.
//   A faulting request goes IDLE -> RESP directly.
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   req_valid   in   1  request present
//   req_ready   out  1  unit can accept a request (IDLE only)
//   req_we      in   1  1 = store, 0 = load
//   req_funct3  in   3  RISC-V size/sign code
//   req_addr    in  64  byte address
//   req_wdata   in  64  right-justified store data
//   resp_valid  out  1  one-cycle completion pulse
//   resp_rdata  out 64  extended load data, 0 for stores and faults
//   resp_fault  out  1  misaligned / illegal, valid with resp_valid
//   mem_a       out 64  doubleword-aligned memory address
//   mem_we      out  1  memory write enable
//   mem_wd      out 64  merged write doubleword
//   mem_rd      in  64  combinational memory read data
// ---------------------------------------------------------------------------
module lsu_rmw
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] mem_a,
  output logic        mem_we,
  output logic [63:0] mem_wd,
  input  logic [63:0] mem_rd
);

  lsu_state_t  state;
  lsu_state_t  state_next;

  // Request fields held from the accept edge until the response.
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;

  // Doubleword read in ACCESS and merged with store data in WRITE.
  logic [63:0] merge_buf;

  logic        accept;
  logic        req_fault;
  logic [63:0] align_rd;
  logic [63:0] load_data;
  logic [63:0] merged;
  logic [63:0] line_addr;

  assign accept    = req_valid & req_ready;
  assign req_fault = access_fault(req_we, req_funct3, req_addr[2:0]);
  assign line_addr = {lat_addr[63:3], 3'b000};

  // The aligner serves both phases:
  //   - ACCESS: it extracts load lanes from live memory data;
  //   - WRITE:  it merges into the buffered copy.
  // The buffer is used in WRITE so that memory is sampled only at the end of
  // ACCESS.
  assign align_rd = (state == ST_WRITE) ? merge_buf : mem_rd;

  lsu_lane_align u_align (
    .funct3    (lat_funct3),
    .offset    (lat_addr[2:0]),
    .rd        (align_rd),
    .wdata     (lat_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // State register. The asynchronous reset returns straight to IDLE, and the
  // memory-side outputs are decoded from state alone. As a result, asserting
  // reset drops mem_we at once, and an in-flight request ends without a
  // response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and all state-decoded outputs. The memory interface is
  // driven only in ACCESS and WRITE, and is held at zero otherwise.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_a      = 64'd0;
    mem_we     = 1'b0;
    mem_wd     = 64'd0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_fault ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_a      = line_addr;
        state_next = lat_we ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_a      = line_addr;
        mem_we     = 1'b1;
        mem_wd     = merged;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request latches, merge buffer and registered response fields.
  // - The response fields are zeroed on accept, so a store or fault reports
  //   rdata 0. A load overwrites rdata in ACCESS.
  // - The response fields are cleared again as RESP ends, so they read 0
  //   whenever no response is being presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'd0;
      lat_addr   <= 64'd0;
      lat_wdata  <= 64'd0;
      merge_buf  <= 64'd0;
      resp_rdata <= 64'd0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            resp_rdata <= 64'd0;
            resp_fault <= req_fault;
          end
        end
        ST_ACCESS: begin
          if (lat_we) begin
            merge_buf <= mem_rd;
          end else begin
            resp_rdata <= load_data;
          end
        end
        ST_RESP: begin
          resp_rdata <= 64'd0;
          resp_fault <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// ---------------------------------------------------------------------------
// tb_lsu_rmw
//
// Drives lsu_rmw against a word-organised data memory and checks every
// response against a byte-addressed reference memory. Expected load values,
// faults, latencies and write counts come from plain arithmetic on that
// byte array.
// ---------------------------------------------------------------------------
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [63:0] mem_a;
  logic        mem_we;
  logic [63:0] mem_wd;
  logic [63:0] mem_rd;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  lsu_rmw dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_a      (mem_a),
    .mem_we     (mem_we),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Data memory: 32 doublewords, combinational read, clocked write. The
  // preload port fills it while the DUT is held in reset.
  logic [63:0] dmem [0:31];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_idx = 5'd0;
  logic [63:0] pre_data = 64'd0;

  assign mem_rd = dmem[mem_a[7:3]];

  always @(posedge clk) begin
    if (mem_we) dmem[mem_a[7:3]] <= mem_wd;
    else if (pre_we) dmem[pre_idx] <= pre_data;
  end

  // Reference memory, one entry per byte address.
  logic [7:0] ref_bytes [0:255];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int refSize(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic refFault(input logic we, input logic [2:0] f3, input logic [63:0] addr);
    logic illegal;
    illegal = we ? (f3 > 3'd3) : (f3 == 3'd7);
    return illegal || ((int'(addr[7:0]) % refSize(f3)) != 0);
  endfunction

  function automatic logic [63:0] refLoad(input logic [2:0] f3, input logic [63:0] addr);
    int n;
    int base;
    logic [63:0] v;
    n = refSize(f3);
    base = int'(addr[7:0]);
    v = 64'd0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_bytes[base + i]) << (8 * i));
    if (!f3[2] && n < 8 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  function automatic logic [63:0] refWord(input int idx);
    logic [63:0] v;
    v = 64'd0;
    for (int b = 0; b < 8; b++) v[8 * b +: 8] = ref_bytes[idx * 8 + b];
    return v;
  endfunction

  // Presents one request, waits for it to be accepted, then watches the
  // response window.
  // - hold=1 leaves req_valid high after the accept, so the caller can chain
  //   the next request back to back.
  // - waits reports how many extra cycles passed before the unit was ready.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] wdata, input bit hold,
                               output int waits, output logic [63:0] rdata_seen);
    logic exp_fault;
    logic [63:0] exp_rdata;
    int exp_lat;
    int exp_we;
    int cyc;
    int lat;
    int we_cnt;
    int we_cyc;
    bit got;
    logic fault_seen;

    req_we = we;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 8) begin
      @(negedge clk);
      waits++;
      checkOutput("resp_pulse_width", 64'(resp_valid), 64'd0);
    end
    checkOutput("req_ready", 64'(req_ready), 64'd1);

    exp_fault = refFault(we, f3, addr);
    exp_rdata = (!we && !exp_fault) ? refLoad(f3, addr) : 64'd0;
    exp_lat = exp_fault ? 1 : (we ? 3 : 2);
    exp_we = (we && !exp_fault) ? 1 : 0;

    @(posedge clk);
    #1;
    if (!hold) begin
      // Scramble the request after acceptance; the unit must ignore it.
      req_valid = 1'b0;
      req_we = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
    end

    cyc = 0;
    lat = 0;
    we_cnt = 0;
    we_cyc = 0;
    got = 0;
    fault_seen = 1'b0;
    rdata_seen = 64'd0;
    while (!got && cyc < 8) begin
      cyc++;
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        we_cyc = cyc;
        checkOutput("mem_a_write", mem_a, {addr[63:3], 3'b000});
      end
      if (resp_valid) begin
        got = 1;
        lat = cyc;
        fault_seen = resp_fault;
        rdata_seen = resp_rdata;
      end
    end
    checkOutput("resp_seen", 64'(got), 64'd1);
    checkOutput("latency", 64'(lat), 64'(exp_lat));
    checkOutput("fault", 64'(fault_seen), 64'(exp_fault));
    checkOutput("rdata", rdata_seen, exp_rdata);
    checkOutput("mem_we_count", 64'(we_cnt), 64'(exp_we));
    if (exp_we == 1) checkOutput("mem_we_cycle", 64'(we_cyc), 64'd2);

    if (exp_we == 1) begin
      for (int i = 0; i < refSize(f3); i++)
        ref_bytes[int'(addr[7:0]) + i] = wdata[8 * i +: 8];
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] d;
    logic [63:0] rd;
    int wc;
    logic we;
    logic [2:0] f3;
    logic [63:0] a;
    logic [63:0] wd;
    bit hold;

    // Preload memory under reset, mirroring every byte into the reference.
    for (int i = 0; i < 32; i++) begin
      d = (i == 8) ? 64'h8877665544332211 : {$urandom, $urandom};
      @(negedge clk);
      pre_we = 1'b1;
      pre_idx = 5'(i);
      pre_data = d;
      for (int b = 0; b < 8; b++) ref_bytes[i * 8 + b] = d[8 * b +: 8];
    end
    @(negedge clk);
    pre_we = 1'b0;

    checkOutput("reset_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset_rdata", resp_rdata, 64'd0);
    checkOutput("reset_fault", 64'(resp_fault), 64'd0);
    checkOutput("reset_mem_we", 64'(mem_we), 64'd0);
    checkOutput("reset_mem_a", mem_a, 64'd0);
    checkOutput("reset_mem_wd", mem_wd, 64'd0);
    rst_n = 1'b1;

    // Signed and unsigned byte loads of the top lane.
    applyStimulus(1'b0, 3'b000, 64'h47, 64'd0, 0, wc, rd);
    checkOutput("first_accept_wait", 64'(wc), 64'd0);
    checkOutput("lb_value", rd, 64'hFFFFFFFFFFFFFF88);
    applyStimulus(1'b0, 3'b100, 64'h47, 64'd0, 0, wc, rd);
    checkOutput("lbu_value", rd, 64'h0000000000000088);

    // Reset asserted during the WRITE of a word store.
    @(negedge clk);
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 64'h40;
    req_wdata = {$urandom, $urandom};
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_access_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    checkOutput("rst_write_we", 64'(mem_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_we", 64'(mem_we), 64'd0);
    checkOutput("rst_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_mem_a", mem_a, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_no_resp", 64'(resp_valid), 64'd0);
    end
    checkOutput("rst_word8", dmem[8], 64'h8877665544332211);

    // Halfword store in the middle of the doubleword.
    applyStimulus(1'b1, 3'b001, 64'h42, 64'h000000000000ABCD, 0, wc, rd);
    checkOutput("sh_word8", dmem[8], 64'h88776655ABCD2211);

    // Misaligned word load and illegal load encoding.
    applyStimulus(1'b0, 3'b010, 64'h41, 64'd0, 0, wc, rd);
    checkOutput("lw_mis_word8", dmem[8], 64'h88776655ABCD2211);
    applyStimulus(1'b0, 3'b111, 64'h40, 64'd0, 0, wc, rd);

    // Store then load with req_valid held high across both.
    applyStimulus(1'b1, 3'b011, 64'h48, 64'h0123456789ABCDEF, 1, wc, rd);
    applyStimulus(1'b0, 3'b011, 64'h48, 64'd0, 0, wc, rd);
    checkOutput("held_accept_wait", 64'(wc), 64'd1);
    checkOutput("ld_value", rd, 64'h0123456789ABCDEF);

    // Random mix of sizes, directions, alignments and back-to-back holds.
    for (int t = 0; t < 80; t++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = 64'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) a = a & ~64'(refSize(f3) - 1);
      wd = {$urandom, $urandom};
      hold = (t < 79) && ($urandom_range(0, 3) == 0);
      applyStimulus(we, f3, a, wd, hold, wc, rd);
    end

    @(negedge clk);
    for (int i = 0; i < 32; i++) checkOutput($sformatf("mem_word_%0d", i), dmem[i], refWord(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
